// File: rtl/uart_pixel_rx.sv
// uart_pixel_rx: UART receiver that packs BYTES_PER_PIX characters into pixel words for frame RAM
module uart_pixel_rx #(
    parameter int CLKS_PER_BIT  = 4,
    parameter int DATA_BITS     = 8,
    parameter int MSB_FIRST     = 1,
    parameter int PARITY        = 0,
    parameter int BYTES_PER_PIX = 3,
    parameter int FRAME_PIX     = 76800,
    parameter int ADDR_W        = 17
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_din,
    output logic [BYTES_PER_PIX*DATA_BITS-1:0] o_pic_out,
    output logic [ADDR_W-1:0]                  o_addr,
    output logic                               o_wr_ram,
    output logic                               o_pic_done,
    output logic                               o_frame_err,
    output logic                               o_parity_err
);
    localparam int PW = BYTES_PER_PIX * DATA_BITS;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int IW = $clog2(BYTES_PER_PIX + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;

    state_t                 r_state, w_next;
    logic                   r_din_m, r_din_s;
    logic [TW-1:0]          r_tmr;
    logic [BW-1:0]          r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic [PW-1:0]          r_pix, w_pix_nxt;
    logic [IW-1:0]          r_idx;
    logic                   r_par_bad;
    logic                   w_half, w_tick, w_last, w_smp, w_stop, w_good, w_pix_done, w_addr_last;

    // two-flop synchroniser for the asynchronous serial line, idling high
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_din_m <= 1'b1;
            r_din_s <= 1'b1;
        end else begin
            r_din_m <= i_din;
            r_din_s <= r_din_m;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // next-state logic and per-cycle sampling decisions
    always_comb begin
        w_half      = r_tmr == TW'(CLKS_PER_BIT / 2 - 1);
        w_tick      = r_tmr == TW'(CLKS_PER_BIT - 1);
        w_last      = r_bit_cnt == BW'(DATA_BITS - 1);
        w_smp       = (r_state == START && w_half) ||
                      ((r_state == DATA || r_state == PAR || r_state == STOP) && w_tick);
        w_stop      = r_state == STOP && w_tick;
        w_good      = w_stop && r_din_s && !r_par_bad;
        w_pix_done  = w_good && r_idx == IW'(BYTES_PER_PIX - 1);
        w_addr_last = o_addr == ADDR_W'(FRAME_PIX - 1);
        w_shift_nxt = (MSB_FIRST != 0) ? {r_shift[DATA_BITS-2:0], r_din_s}
                                       : {r_din_s, r_shift[DATA_BITS-1:1]};
        w_pix_nxt   = PW'({r_pix, r_shift});
        w_next      = r_state;
        case (r_state)
            IDLE:      if (!r_din_s) w_next = START;
            START:     if (w_half) w_next = r_din_s ? IDLE : DATA;
            DATA:      if (w_tick && w_last) w_next = (PARITY != 0) ? PAR : STOP;
            PAR:       if (w_tick) w_next = STOP;
            STOP:      if (w_tick) w_next = r_din_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (r_din_s) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // bit timing, character deserialisation, pixel assembly and RAM write sequencing
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tmr        <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_pix        <= '0;
            r_idx        <= '0;
            r_par_bad    <= 1'b0;
            o_pic_out    <= '0;
            o_addr       <= '0;
            o_wr_ram     <= 1'b0;
            o_pic_done   <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            r_tmr        <= (r_state == IDLE || r_state == WAIT_IDLE || w_smp) ? '0 : r_tmr + 1'b1;
            r_bit_cnt    <= (r_state != DATA) ? '0 : r_bit_cnt + BW'(w_tick);
            r_par_bad    <= (r_state == IDLE) ? 1'b0 :
                            (r_state == PAR && w_tick) ? ((^r_shift ^ r_din_s) != (PARITY == 2)) :
                            r_par_bad;
            o_frame_err  <= w_stop && !r_din_s;
            o_parity_err <= w_stop && r_par_bad;
            o_wr_ram     <= w_pix_done;
            o_pic_done   <= w_pix_done && w_addr_last;
            r_idx        <= ((w_stop && !w_good) || w_pix_done) ? '0 : w_good ? r_idx + 1'b1 : r_idx;
            if (r_state == DATA && w_tick) r_shift <= w_shift_nxt;
            if (w_good) r_pix <= w_pix_nxt;
            if (w_pix_done) o_pic_out <= w_pix_nxt;
            if (o_wr_ram) o_addr <= w_addr_last ? '0 : o_addr + 1'b1;
        end
    end
endmodule
